// File: rtl/keypad_pkg.sv
// Shared types, key map and row-pattern helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    HOLD     = 2'd3
  } state_t;

  // Indexed by {row, col}; '*' encodes as E and '#' as F.
  localparam logic [3:0] KEY_MAP [NUM_ROWS*NUM_COLS] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // True when exactly one row line is pulled low.
  function automatic logic onehot_low(input logic [NUM_ROWS-1:0] v);
    logic [NUM_ROWS-1:0] inv;
    inv = ~v;
    return (inv != '0) && ((inv & (inv - NUM_ROWS'(1))) == '0);
  endfunction

  function automatic logic [1:0] low_index(input logic [NUM_ROWS-1:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key stream between the keypad scanner (master) and the lock controller (slave).
interface keypad_scanner_if;
  import keypad_pkg::*;

  // key_valid is a one-cycle strobe with no ready: the consumer must take
  // key_val in the strobe cycle; key_val holds its value between strobes.
  logic [3:0] key_val;
  logic       key_valid;
  logic       key_held;
  state_t     dbg_state;

  modport master (output key_val, key_valid, key_held, dbg_state);
  modport slave  (input  key_val, key_valid, key_held, dbg_state);
endinterface

// File: rtl/key_debounce_cnt.sv
// Saturating stable-cycle counter; done_o flags the cycle whose increment reaches MAX.
module key_debounce_cnt #(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic done_o
);

  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = inc_i && !clr_i && (cnt_q >= MAX_V - W'(1));

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with debounced single-key encoding.
// Optional auto-repeat while a key is held: define KEYPAD_AUTO_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 50000,
  parameter int REPEAT_DLY   = 5000000,
  parameter int REPEAT_PER   = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        row,
  output logic [3:0]        col,
  keypad_scanner_if.master  key_if
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

  logic [3:0]        row_m_q, row_s_q;
  state_t            state_q, state_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [3:0]        cap_row_q, cap_row_d;
  logic [3:0]        key_val_q, key_val_d;
  logic press_match, rel_idle, slot_last;
  logic press_inc, press_clr, press_done;
  logic rel_inc, rel_clr, rel_done;
  logic rep_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_m_q <= 4'hF;
      row_s_q <= 4'hF;
    end else begin
      row_m_q <= row;
      row_s_q <= row_m_q;
    end
  end

  assign slot_last   = (slot_q == SLOT_LAST);
  assign press_match = (row_s_q == cap_row_q);
  assign rel_idle    = (row_s_q == 4'hF);

  assign press_inc = (state_q == DEBOUNCE) && press_match;
  assign press_clr = !press_inc;
  assign rel_inc   = (state_q == HOLD) && rel_idle;
  assign rel_clr   = !rel_inc;

  key_debounce_cnt #(.MAX(DEBOUNCE_CNT)) u_press_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (press_clr),
    .inc_i  (press_inc),
    .done_o (press_done)
  );

  key_debounce_cnt #(.MAX(DEBOUNCE_CNT)) u_release_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (rel_clr),
    .inc_i  (rel_inc),
    .done_o (rel_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCAN;
      col_idx_q <= '0;
      slot_q    <= '0;
      cap_row_q <= 4'hF;
      key_val_q <= '0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      slot_q    <= slot_d;
      cap_row_q <= cap_row_d;
      key_val_q <= key_val_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    slot_d    = slot_q;
    cap_row_d = cap_row_q;
    key_val_d = key_val_q;
    case (state_q)
      SCAN: begin
        if (!slot_last) begin
          slot_d = slot_q + SLOT_W'(1);
        end else begin
          slot_d = '0;
          // Multi-low samples (ghosting or chords) are skipped like an idle column.
          if (onehot_low(row_s_q)) begin
            cap_row_d = row_s_q;
            state_d   = DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (!press_match) begin
          col_idx_d = col_idx_q + 2'd1;
          state_d   = SCAN;
        end else if (press_done) begin
          key_val_d = KEY_MAP[{low_index(cap_row_q), col_idx_q}];
          state_d   = EMIT;
        end
      end
      EMIT: state_d = HOLD;
      HOLD: begin
        if (rel_done) begin
          col_idx_d = col_idx_q + 2'd1;
          state_d   = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase
  end

`ifdef KEYPAD_AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_limit;
  logic             rep_first_q, rep_first_d, rep_run;

  assign rep_run   = (state_q == HOLD) && press_match;
  assign rep_limit = rep_first_q ? REP_W'(REPEAT_DLY - 1) : REP_W'(REPEAT_PER - 1);
  assign rep_fire  = rep_run && (rep_cnt_q == rep_limit);

  // The counter restarts on each repeat, so it never passes the limit.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    if (!rep_run) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (rep_fire) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b0;
    end else begin
      rep_cnt_d = rep_cnt_q + REP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  // Repeat strobe is compiled out; the repeat parameters only feed this constant.
  localparam bit REP_CFG_OK = (REPEAT_DLY > 0) && (REPEAT_PER > 0);
  assign rep_fire = 1'b0 && REP_CFG_OK;
`endif

  always_comb begin
    col              = ~(4'b0001 << col_idx_q);
    key_if.key_valid = ((state_q == EMIT) || rep_fire) && !rst;
    key_if.key_held  = (state_q == EMIT) || (state_q == HOLD);
    key_if.key_val   = key_val_q;
    key_if.dbg_state = state_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, key-code scoreboard, vector table.
`timescale 1ns/1ps
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int RDLY     = 40;
  localparam int RPER     = 16;
`ifdef KEYPAD_AUTO_REPEAT_EN
  localparam int N_REP = 5;
`else
  localparam int N_REP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row = 4'hF;
  logic [3:0] col;

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB), .REPEAT_DLY(RDLY), .REPEAT_PER(RPER)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .row    (row),
    .col    (col),
    .key_if (kif)
  );

  always #5 clk = ~clk;

  // Pressed-key mask, bit r*4+c; a row reads low when any pressed key on it sits on the driven column.
  logic [15:0] pressed = '0;
  always @(negedge clk) begin
    logic [3:0] r_v;
    r_v = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) r_v[r] = 1'b0;
    row = r_v;
  end

  logic [3:0] exp_q[$];
  int         pulse_cyc[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic       prev_valid = 1'b0;
  int         rep_off [5] = '{0, 40, 56, 72, 88};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: every strobe must match the oldest expected code.
  always @(negedge clk) begin
    check("col_onehot_low", $countones(~col), 1);
    if (kif.key_valid === 1'b1) begin
      check("no_back_to_back_valid", prev_valid, 0);
      check("pulse_expected", exp_q.size() != 0, 1);
      pulse_cyc.push_back(cyc);
      if (exp_q.size() != 0) check("key_val", kif.key_val, exp_q.pop_front());
    end
    prev_valid = kif.key_valid;
  end

  task automatic press(input int r, input int c);
    @(posedge clk);
    #1 pressed = '0;
    pressed[r*4+c] = 1'b1;
  endtask

  task automatic release_keys();
    @(posedge clk);
    #1 pressed = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    int         r;
    int         c;
    int         hold;
    logic [3:0] code;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [3:0] e;
    int         t;
    bit         seen_c3;

    vecs[0] = '{r: 1, c: 1, hold: 40, code: 4'h5};
    vecs[1] = '{r: 0, c: 0, hold: 40, code: 4'h1};
    vecs[2] = '{r: 0, c: 1, hold: 40, code: 4'h2};
    vecs[3] = '{r: 0, c: 2, hold: 40, code: 4'h3};
    vecs[4] = '{r: 1, c: 0, hold: 40, code: 4'h4};
    vecs[5] = '{r: 0, c: 3, hold: 40, code: 4'hA};
    vecs[6] = '{r: 3, c: 1, hold: 40, code: 4'h0};
    vecs[7] = '{r: 3, c: 2, hold: 40, code: 4'hF};
    vecs[8] = '{r: 3, c: 3, hold: 40, code: 4'hD};

    // Reset held three cycles.
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_col", col, 4'b1110);
      check("rst_valid", kif.key_valid, 0);
      check("rst_val", kif.key_val, 0);
      check("rst_held", kif.key_held, 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Column rotation with no key: four cycles per column.
    for (int j = 0; j < 17; j++) begin
      @(negedge clk);
      e = ~(4'b0001 << ((j / 4) % 4));
      check($sformatf("col_rot_%0d", j), col, e);
    end

    // Single presses with release timing and key_val hold.
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(vecs[i].code);
      press(vecs[i].r, vecs[i].c);
      idle(vecs[i].hold);
      check($sformatf("pulse_seen_%0d", i), exp_q.size(), 0);
      check($sformatf("held_pressed_%0d", i), kif.key_held, 1);
      exp_q.delete();
      release_keys();
      idle(10);
      check($sformatf("held_release_edge_%0d", i), kif.key_held, 1);
      idle(1);
      check($sformatf("held_cleared_%0d", i), kif.key_held, 0);
      check($sformatf("val_stable_%0d", i), kif.key_val, vecs[i].code);
      idle(9);
    end

    // Bouncing '5': 3-cycle toggles never qualify, then a stable press does.
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1 pressed = (k % 2 == 0) ? 16'h0020 : 16'h0000;
      repeat (2) @(posedge clk);
    end
    exp_q.push_back(4'h5);
    @(posedge clk);
    #1 pressed = 16'h0020;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("bounce_pulse", exp_q.size(), 0);
    exp_q.delete();
    release_keys();
    idle(20);

    // Ghost: rows 0 and 2 low on column 0 must be skipped while scanning continues.
    @(posedge clk);
    #1 pressed = 16'h0101;
    seen_c3 = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (col == 4'b0111) seen_c3 = 1'b1;
    end
    check("ghost_scan_continues", seen_c3, 1);
    check("ghost_not_held", kif.key_held, 0);
    release_keys();
    idle(20);
    exp_q.push_back(4'hE);
    press(3, 0);
    idle(40);
    check("star_pulse", exp_q.size(), 0);
    exp_q.delete();
    release_keys();
    idle(20);

    // Reset during DEBOUNCE of '6' aborts the press.
    press(1, 2);
    t = 0;
    while (kif.dbg_state != DEBOUNCE && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("reached_debounce", kif.dbg_state == DEBOUNCE, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", kif.key_valid, 0);
    @(negedge clk);
    check("rst_mid_col", col, 4'b1110);
    check("rst_mid_val", kif.key_val, 0);
    check("rst_mid_state", kif.dbg_state, SCAN);
    release_keys();
    @(posedge clk);
    #1 rst = 1'b0;
    idle(30);

    // Long hold of '0': repeat strobes when enabled, otherwise a single pulse.
    pulse_cyc.delete();
    for (int i = 0; i < N_REP; i++) exp_q.push_back(4'h0);
    press(3, 1);
    t = 0;
    while (pulse_cyc.size() == 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("hold_first_pulse", pulse_cyc.size() != 0, 1);
    repeat (95) @(posedge clk);
    release_keys();
    idle(30);
    check("hold_pulse_count", pulse_cyc.size(), N_REP);
    for (int i = 1; i < N_REP; i++)
      if (i < pulse_cyc.size())
        check($sformatf("repeat_offset_%0d", i), pulse_cyc[i] - pulse_cyc[0], rep_off[i]);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
